// File: rtl/ramp_sequencer.sv
// ramp_sequencer: sequences one measurement cycle (arm, trigger, ramp up,
// fixed-length ADC acquisition, ramp down, re-reset) over the ramping fabric.
// Optional feature macro: RAMP_TIMEOUT_EN (ramp-phase watchdog, sticky timeout_err).
module ramp_sequencer #(
  parameter int unsigned RAMP_TIMEOUT_CYCLES = 125000000,
  parameter int unsigned ACQ_WIDTH           = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [1:0]           enable_mask,
  input  logic                 seq_start,
  input  logic                 seq_abort,
  input  logic                 fault_in,
  input  logic                 trigger_in,
  input  logic [ACQ_WIDTH-1:0] acq_length,
  input  logic [1:0]           ramp_state_0,
  input  logic [1:0]           ramp_state_1,
  output logic [1:0]           ramping_enable,
  output logic [1:0]           start_ramp_down,
  output logic                 dac_aresetn,
  output logic                 ram_aresetn,
  output logic [2:0]           seq_state,
  output logic [ACQ_WIDTH-1:0] acq_count,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_ACQ       = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_DONE      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic [1:0]           mask_q, mask_d;
  logic [ACQ_WIDTH-1:0] len_q, len_d;
  logic [ACQ_WIDTH-1:0] acq_d;
  logic [1:0]           ren_d, srd_d;
  logic                 dac_d, ram_d, busy_d, done_d;
  logic                 start_rise_c, plateau_c, idle_c, tmo_hit_c;

  assign start_rise_c = seq_start & ~start_q;
  assign plateau_c    = ((ramp_state_0 == 2'b10) | ~mask_q[0]) & ((ramp_state_1 == 2'b10) | ~mask_q[1]);
  assign idle_c       = ((ramp_state_0 == 2'b00) | ~mask_q[0]) & ((ramp_state_1 == 2'b00) | ~mask_q[1]);
  assign seq_state    = state_q;

  // State, latched config and registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= S_IDLE;
      start_q         <= 1'b0;
      mask_q          <= 2'b00;
      len_q           <= '0;
      acq_count       <= '0;
      ramping_enable  <= 2'b00;
      start_ramp_down <= 2'b00;
      dac_aresetn     <= 1'b0;
      ram_aresetn     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_q         <= seq_start;
      mask_q          <= mask_d;
      len_q           <= len_d;
      acq_count       <= acq_d;
      ramping_enable  <= ren_d;
      start_ramp_down <= srd_d;
      dac_aresetn     <= dac_d;
      ram_aresetn     <= ram_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  // Next state plus output decode of the state being entered
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    len_d   = len_q;
    acq_d   = acq_count;
    ren_d   = 2'b00;
    srd_d   = 2'b00;
    dac_d   = 1'b0;
    ram_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise_c && (enable_mask != 2'b00)) begin
          mask_d  = enable_mask;
          len_d   = acq_length;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (fault_in)        state_d = S_FAULT;
        else if (seq_abort)  state_d = S_IDLE;
        else if (trigger_in) state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (fault_in || tmo_hit_c) state_d = S_FAULT;
        else if (seq_abort)        state_d = S_RAMP_DOWN;
        else if (plateau_c) begin
          if (len_q != '0) begin
            state_d = S_ACQ;
            acq_d   = '0;
          end else begin
            state_d = S_RAMP_DOWN;
          end
        end
      end
      S_ACQ: begin
        if (fault_in)       state_d = S_FAULT;
        else if (seq_abort) state_d = S_RAMP_DOWN;
        else begin
          acq_d = acq_count + ACQ_WIDTH'(1);
          if (acq_count == len_q - ACQ_WIDTH'(1)) state_d = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (fault_in || tmo_hit_c) state_d = S_FAULT;
        else if (idle_c)           state_d = S_DONE;
      end
      S_DONE: begin
        if (fault_in) state_d = S_FAULT;
        else          state_d = S_IDLE;
      end
      S_FAULT: begin
        if (!fault_in && !seq_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_ARM:       busy_d = 1'b1;
      S_RAMP_UP:   begin busy_d = 1'b1; dac_d = 1'b1; ren_d = mask_d; end
      S_ACQ:       begin busy_d = 1'b1; dac_d = 1'b1; ren_d = mask_d; ram_d = 1'b1; end
      S_RAMP_DOWN: begin busy_d = 1'b1; dac_d = 1'b1; ren_d = mask_d; srd_d = mask_d; end
      S_DONE:      begin busy_d = 1'b1; done_d = 1'b1; end
      S_FAULT:     busy_d = 1'b1;
      default:     busy_d = 1'b0;
    endcase
  end

`ifdef RAMP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(RAMP_TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             in_ramp_c;

  assign in_ramp_c = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
  assign tmo_hit_c = in_ramp_c && (tmo_cnt_q == TMO_W'(RAMP_TIMEOUT_CYCLES - 1));

  // Ramp-phase cycle counter, cleared on every state change
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                tmo_cnt_q <= '0;
    else if (state_d != state_q) tmo_cnt_q <= '0;
    else if (in_ramp_c)          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  // Sticky timeout flag, cleared by an accepted start
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                                         timeout_err <= 1'b0;
    else if ((state_q == S_IDLE) && (state_d == S_ARM))   timeout_err <= 1'b0;
    else if (tmo_hit_c)                                   timeout_err <= 1'b1;
  end
`else
  assign tmo_hit_c   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
